// File: rtl/axi_sram_slave_if.sv
// axi_sram_slave_if: AXI3-subset AR/R/AW/W/B signal bundle with master and slave views
interface axi_sram_slave_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  modport master (
    output arid, araddr, arlen, arvalid, rready,
    output awid, awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
    input  arready, rid, rdata, rresp, rlast, rvalid,
    input  awready, wready, bid, bresp, bvalid
  );
  modport slave (
    input  arid, araddr, arlen, arvalid, rready,
    input  awid, awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
    output arready, rid, rdata, rresp, rlast, rvalid,
    output awready, wready, bid, bresp, bvalid
  );
endinterface

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI3-subset word RAM responder, one read and one write burst in flight; define RAND_DELAY_EN for LFSR-driven handshake stalls
module axi_sram_slave #(
  parameter int          MEM_AW    = 12,
  parameter logic [15:0] LFSR_SEED = 16'hA5C3
) (
  input logic             aclk,
  input logic             aresetn,
  axi_sram_slave_if.slave bus
);
  localparam int DEPTH = 2 ** MEM_AW;
  typedef enum logic {R_IDLE, R_DATA} r_st_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_st_e;
  logic [31:0] mem [DEPTH];
  r_st_e             r_st_q, r_st_d;
  logic [3:0]        r_id_q, r_id_d, r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic [MEM_AW-1:0] r_idx_q, r_idx_d, rd_idx;
  logic              r_err_q, r_err_d;
  logic [31:0]       rd_word_q;
  w_st_e             w_st_q, w_st_d;
  logic [3:0]        w_id_q, w_id_d, w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic [MEM_AW-1:0] w_idx_q, w_idx_d;
  logic              w_err_q, w_err_d, w_bad_q, w_bad_d;
  logic stall, r_go, b_go;
  logic ar_hs, r_hs, aw_hs, w_hs, b_hs, r_last, w_last, rd_load, w_we;
  logic unused_bits;
  assign unused_bits = ^{bus.araddr[1:0], bus.arlen[7:4], bus.awaddr[1:0], bus.awlen[7:4]};
`ifdef RAND_DELAY_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic        r_hold_q, r_hold_d, b_hold_q, b_hold_d;
  // step the stall LFSR and remember valids still waiting for their handshake
  always_comb begin
    lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    r_hold_d = bus.rvalid && !bus.rready;
    b_hold_d = bus.bvalid && !bus.bready;
  end
  // stall generator state
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      lfsr_q   <= LFSR_SEED;
      r_hold_q <= 1'b0;
      b_hold_q <= 1'b0;
    end else begin
      lfsr_q   <= lfsr_d;
      r_hold_q <= r_hold_d;
      b_hold_q <= b_hold_d;
    end
  assign stall = lfsr_q[1:0] == 2'b00;
  assign r_go  = r_hold_q || lfsr_q[3:2] != 2'b00;
  assign b_go  = b_hold_q || lfsr_q[3:2] != 2'b00;
`else
  logic unused_seed;
  assign unused_seed = ^LFSR_SEED;
  assign stall = 1'b0;
  assign r_go  = 1'b1;
  assign b_go  = 1'b1;
`endif
  assign r_last      = r_cnt_q == r_len_q;
  assign w_last      = w_cnt_q == w_len_q;
  assign bus.arready = aresetn && r_st_q == R_IDLE && !stall;
  assign bus.rvalid  = r_st_q == R_DATA && r_go;
  assign bus.rid     = r_id_q;
  assign bus.rdata   = (r_st_q == R_DATA && !r_err_q) ? rd_word_q : '0;
  assign bus.rresp   = (r_st_q == R_DATA && r_err_q) ? 2'b10 : 2'b00;
  assign bus.rlast   = r_st_q == R_DATA && r_last;
  assign bus.awready = aresetn && w_st_q == W_IDLE && !stall;
  assign bus.wready  = w_st_q == W_DATA && !stall;
  assign bus.bvalid  = w_st_q == W_RESP && b_go;
  assign bus.bid     = w_id_q;
  assign bus.bresp   = (w_st_q == W_RESP && (w_err_q || w_bad_q)) ? 2'b10 : 2'b00;
  assign ar_hs = bus.arvalid && bus.arready;
  assign r_hs  = bus.rvalid && bus.rready;
  assign aw_hs = bus.awvalid && bus.awready;
  assign w_hs  = bus.wvalid && bus.wready;
  assign b_hs  = bus.bvalid && bus.bready;
  // read channel: latch the request, then walk the burst one word per accepted beat
  always_comb begin
    r_st_d  = r_st_q;
    r_id_d  = r_id_q;
    r_len_d = r_len_q;
    r_cnt_d = r_cnt_q;
    r_idx_d = r_idx_q;
    r_err_d = r_err_q;
    rd_load = 1'b0;
    rd_idx  = r_idx_q + 1'b1;
    if (ar_hs) begin
      r_st_d  = R_DATA;
      r_id_d  = bus.arid;
      r_len_d = bus.arlen[3:0];
      r_cnt_d = '0;
      r_idx_d = bus.araddr[MEM_AW+1:2];
      r_err_d = |bus.araddr[31:MEM_AW+2];
      rd_load = 1'b1;
      rd_idx  = bus.araddr[MEM_AW+1:2];
    end else if (r_hs) begin
      r_st_d  = r_last ? R_IDLE : R_DATA;
      r_cnt_d = r_last ? r_cnt_q : r_cnt_q + 1'b1;
      r_idx_d = r_last ? r_idx_q : rd_idx;
      rd_load = !r_last;
    end
  end
  // write channel: latch the request, absorb beats, then hold the response until taken
  always_comb begin
    w_st_d  = w_st_q;
    w_id_d  = w_id_q;
    w_len_d = w_len_q;
    w_cnt_d = w_cnt_q;
    w_idx_d = w_idx_q;
    w_err_d = w_err_q;
    w_bad_d = w_bad_q;
    w_we    = 1'b0;
    if (aw_hs) begin
      w_st_d  = W_DATA;
      w_id_d  = bus.awid;
      w_len_d = bus.awlen[3:0];
      w_cnt_d = '0;
      w_idx_d = bus.awaddr[MEM_AW+1:2];
      w_err_d = |bus.awaddr[31:MEM_AW+2];
      w_bad_d = 1'b0;
    end else if (w_hs) begin
      w_st_d  = w_last ? W_RESP : W_DATA;
      w_cnt_d = w_cnt_q + 1'b1;
      w_idx_d = w_idx_q + 1'b1;
      w_bad_d = w_bad_q || (bus.wlast != w_last);
      w_we    = !w_err_q;
    end else if (b_hs) begin
      w_st_d = W_IDLE;
    end
  end
  // channel state registers; reset abandons any burst in flight
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      r_st_q  <= R_IDLE;
      r_id_q  <= '0;
      r_len_q <= '0;
      r_cnt_q <= '0;
      r_idx_q <= '0;
      r_err_q <= 1'b0;
      w_st_q  <= W_IDLE;
      w_id_q  <= '0;
      w_len_q <= '0;
      w_cnt_q <= '0;
      w_idx_q <= '0;
      w_err_q <= 1'b0;
      w_bad_q <= 1'b0;
    end else begin
      r_st_q  <= r_st_d;
      r_id_q  <= r_id_d;
      r_len_q <= r_len_d;
      r_cnt_q <= r_cnt_d;
      r_idx_q <= r_idx_d;
      r_err_q <= r_err_d;
      w_st_q  <= w_st_d;
      w_id_q  <= w_id_d;
      w_len_q <= w_len_d;
      w_cnt_q <= w_cnt_d;
      w_idx_q <= w_idx_d;
      w_err_q <= w_err_d;
      w_bad_q <= w_bad_d;
    end
  // registered RAM read; a same-cycle write to the word is seen only by later reads
  always_ff @(posedge aclk)
    if (rd_load) rd_word_q <= mem[rd_idx];
  // byte-lane RAM write; contents survive reset
  always_ff @(posedge aclk)
    if (w_we)
      for (int b = 0; b < 4; b++)
        if (bus.wstrb[b]) mem[w_idx_q][8*b +: 8] <= bus.wdata[8*b +: 8];
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: table vectors, directed burst/error/reset sequences and random bursts against a word-array model
module tb_axi_sram_slave;
  localparam int LIM = 64;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] mem_m [4096];
  logic [31:0] wbuf [16];
  logic [3:0]  sbuf [16];
  logic [31:0] rbuf [16];
  logic        rlbuf [16];
  typedef struct {
    logic [31:0] addr;
    logic [31:0] pre;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;
  vec_t vt [8];
  axi_sram_slave_if bus();
  axi_sram_slave #(.MEM_AW(12), .LFSR_SEED(16'hA5C3)) dut (.aclk(clk), .aresetn(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask
  task automatic tmo(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: no handshake within %0d cycles", name, LIM);
  endtask
  task automatic idle();
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
  endtask
  // burst write of wbuf/sbuf; bad>=0 puts wlast on that beat instead of the last one
  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len, input int bad,
                          input int pct, output logic [1:0] resp);
    int t, hold, idx;
    logic err;
    logic [1:0] exp;
    logic [31:0] bs;
    err = addr[31:14] != 0;
    exp = (err || bad >= 0) ? 2'b10 : 2'b00;
    bus.awid = id; bus.awaddr = addr; bus.awlen = 8'(len); bus.awvalid = 1'b1;
    t = 0;
    while (!bus.awready && t < LIM) begin @(negedge clk); t++; end
    if (t >= LIM) tmo("aw_ready");
    @(negedge clk);
    bus.awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if (pct > 0 && $urandom_range(99) < pct) begin bus.wvalid = 1'b0; @(negedge clk); end
      bus.wdata = wbuf[i]; bus.wstrb = sbuf[i];
      bus.wlast = (bad < 0) ? (i == len) : (i == bad);
      bus.wvalid = 1'b1;
      t = 0;
      while (!bus.wready && t < LIM) begin @(negedge clk); t++; end
      if (t >= LIM) tmo("w_ready");
      @(negedge clk);
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    t = 0;
    while (!bus.bvalid && t < LIM) begin @(negedge clk); t++; end
    if (t >= LIM) tmo("b_valid");
    hold = pct > 0 ? int'($urandom_range(2)) : 0;
    for (int h = 0; h < hold; h++) begin
      bs = {26'b0, bus.bid, bus.bresp};
      @(negedge clk);
      chk("b_held_valid", 32'(bus.bvalid), 32'd1);
      chk("b_held_stable", {26'b0, bus.bid, bus.bresp}, bs);
    end
    bus.bready = 1'b1;
    resp = bus.bresp;
    chk("bid", 32'(bus.bid), 32'(id));
    chk("bresp", 32'(bus.bresp), 32'(exp));
    @(negedge clk);
    bus.bready = 1'b0;
    if (!err)
      for (int i = 0; i <= len; i++) begin
        idx = (int'(addr[13:2]) + i) % 4096;
        for (int b = 0; b < 4; b++)
          if (sbuf[i][b]) mem_m[idx][8*b +: 8] = wbuf[i][8*b +: 8];
      end
  endtask
  // burst read checked beat by beat; stall_beat holds rready low 2 cycles on that beat
  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len, input int stall_beat,
                         input int pct, output int cyc);
    int t, hold, idx;
    logic err;
    logic [31:0] snap;
    err = addr[31:14] != 0;
    bus.arid = id; bus.araddr = addr; bus.arlen = 8'(len); bus.arvalid = 1'b1;
    t = 0;
    while (!bus.arready && t < LIM) begin @(negedge clk); t++; end
    if (t >= LIM) tmo("ar_ready");
    @(negedge clk);
    bus.arvalid = 1'b0;
    cyc = 0;
    for (int i = 0; i <= len; i++) begin
      bus.rready = 1'b0;
      t = 0;
      while (!bus.rvalid && t < LIM) begin @(negedge clk); t++; cyc++; end
      if (t >= LIM) begin tmo("r_valid"); break; end
      hold = (i == stall_beat) ? 2 : (pct > 0 && $urandom_range(99) < pct) ? int'($urandom_range(1, 3)) : 0;
      snap = bus.rdata;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk); cyc++;
        chk("r_held_valid", 32'(bus.rvalid), 32'd1);
        chk("r_held_data", bus.rdata, snap);
      end
      idx = (int'(addr[13:2]) + i) % 4096;
      chk("rdata", bus.rdata, err ? 32'd0 : mem_m[idx]);
      chk("rresp", 32'(bus.rresp), err ? 32'd2 : 32'd0);
      chk("rlast", 32'(bus.rlast), 32'(i == len));
      chk("rid", 32'(bus.rid), 32'(id));
      rbuf[i] = bus.rdata;
      rlbuf[i] = bus.rlast;
      bus.rready = 1'b1;
      @(negedge clk); cyc++;
    end
    bus.rready = 1'b0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int t, cyc;
    logic [1:0] resp;
    vt[0] = '{32'h0000_0100, 32'h0000_0000, 32'hDEAD_BEEF, 4'hF, 32'hDEAD_BEEF, 2'b00};
    vt[1] = '{32'h0000_0104, 32'hFFFF_FFFF, 32'h1122_3344, 4'h5, 32'hFF22_FF44, 2'b00};
    vt[2] = '{32'h0000_0108, 32'h1234_5678, 32'hAABB_CCDD, 4'h8, 32'hAA34_5678, 2'b00};
    vt[3] = '{32'h0000_010C, 32'h1234_5678, 32'hAABB_CCDD, 4'h0, 32'h1234_5678, 2'b00};
    vt[4] = '{32'h0000_3FFC, 32'h0000_0000, 32'h0BAD_F00D, 4'hF, 32'h0BAD_F00D, 2'b00};
    vt[5] = '{32'h0000_0113, 32'h0000_0000, 32'hCAFE_F00D, 4'h3, 32'h0000_F00D, 2'b00};
    vt[6] = '{32'h8000_0100, 32'h0000_0000, 32'h5555_5555, 4'hF, 32'h0000_0000, 2'b10};
    vt[7] = '{32'h0000_4000, 32'h0000_0000, 32'h6666_6666, 4'hF, 32'h0000_0000, 2'b10};
    idle();
    @(negedge clk); @(negedge clk);
    chk("rst_arready", 32'(bus.arready), 32'd0);
    chk("rst_awready", 32'(bus.awready), 32'd0);
    chk("rst_wready", 32'(bus.wready), 32'd0);
    chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
    chk("rst_bvalid", 32'(bus.bvalid), 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_resp", {28'b0, bus.rresp, bus.bresp}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
`ifndef RAND_DELAY_EN
    chk("idle_arready", 32'(bus.arready), 32'd1);
    chk("idle_awready", 32'(bus.awready), 32'd1);
`endif
    bus.wvalid = 1'b1; bus.wdata = 32'h1357_9BDF; bus.wstrb = 4'hF; bus.wlast = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_wready", 32'(bus.wready), 32'd0);
    end
    idle();
    for (int k = 0; k < 8; k++) begin
      wbuf[0] = vt[k].pre; sbuf[0] = 4'hF;
      do_write(4'(k), vt[k].addr, 0, -1, 0, resp);
      wbuf[0] = vt[k].wdata; sbuf[0] = vt[k].strb;
      do_write(4'(k + 1), vt[k].addr, 0, -1, 0, resp);
      chk("tbl_bresp", 32'(resp), 32'(vt[k].exp_resp));
      do_read(4'(k + 2), vt[k].addr, 0, -1, 0, cyc);
      chk("tbl_rdata", rbuf[0], vt[k].exp_data);
      chk("tbl_rlast", 32'(rlbuf[0]), 32'd1);
`ifndef RAND_DELAY_EN
      chk("tbl_rlat", 32'(cyc), 32'd1);
`endif
    end
    do_read(4'h3, 32'h0000_0100, 0, -1, 0, cyc);
    chk("err_ram_kept", rbuf[0], 32'hDEAD_BEEF);
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hA000_0000 + 32'(i); sbuf[i] = 4'hF; end
    do_write(4'h4, 32'h0000_0200, 3, -1, 0, resp);
    do_read(4'h5, 32'h0000_0200, 3, 2, 0, cyc);
    for (int i = 0; i < 4; i++) begin
      chk("burst_data", rbuf[i], 32'hA000_0000 + 32'(i));
      chk("burst_rlast", 32'(rlbuf[i]), 32'(i == 3));
    end
`ifndef RAND_DELAY_EN
    chk("burst_stall_cycles", 32'(cyc), 32'd6);
    do_read(4'h6, 32'h0000_0200, 3, -1, 0, cyc);
    chk("burst_b2b_cycles", 32'(cyc), 32'd4);
`endif
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hB000_0000 + 32'(i); sbuf[i] = 4'hF; end
    do_write(4'h7, 32'h0000_3FF8, 3, -1, 0, resp);
    do_read(4'h8, 32'h0000_3FF8, 3, -1, 0, cyc);
    do_read(4'h9, 32'h0000_0000, 0, -1, 0, cyc);
    chk("wrap_word0", rbuf[0], 32'hB000_0002);
    wbuf[0] = 32'hC0C0_C0C0; wbuf[1] = 32'hC1C1_C1C1; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
    do_write(4'hA, 32'h0000_0300, 1, 0, 0, resp);
    chk("wlast_early", 32'(resp), 32'd2);
    do_write(4'hB, 32'h0000_0308, 1, 99, 0, resp);
    chk("wlast_missing", 32'(resp), 32'd2);
    do_read(4'hC, 32'h0000_0300, 3, -1, 0, cyc);
    bus.arid = 4'h7; bus.araddr = 32'h0000_0200; bus.arlen = 8'd3; bus.arvalid = 1'b1;
    t = 0;
    while (!bus.arready && t < LIM) begin @(negedge clk); t++; end
    if (t >= LIM) tmo("rst_ar_ready");
    @(negedge clk);
    bus.arvalid = 1'b0; bus.rready = 1'b1;
    t = 0;
    while (!bus.rvalid && t < LIM) begin @(negedge clk); t++; end
    @(negedge clk);
    bus.rready = 1'b0;
    t = 0;
    while (!bus.rvalid && t < LIM) begin @(negedge clk); t++; end
    chk("rst_pre_rvalid", 32'(bus.rvalid), 32'd1);
    chk("rst_pre_rdata", bus.rdata, 32'hA000_0001);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rvalid_drop", 32'(bus.rvalid), 32'd0);
    chk("rst_arready_low", 32'(bus.arready), 32'd0);
    idle();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_read(4'hD, 32'h0000_0200, 3, -1, 0, cyc);
    chk("rst_ram_kept", rbuf[3], 32'hA000_0003);
    for (int blk = 0; blk < 16; blk++) begin
      for (int i = 0; i < 16; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
      do_write(4'(blk), 32'(blk * 64), 15, -1, 0, resp);
    end
    for (int n = 0; n < 150; n++) begin
      int len, bad;
      logic [31:0] a;
      len = int'($urandom_range(15));
      a = {18'b0, 12'($urandom_range(0, 240)), 2'($urandom)};
      if ($urandom_range(9) == 0) a[31] = 1'b1;
      if ($urandom_range(1) == 1) begin
        for (int i = 0; i < 16; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'($urandom); end
        bad = ($urandom_range(9) == 0) ? (len > 0 ? int'($urandom_range(len - 1)) : 99) : -1;
        do_write(4'($urandom), a, len, bad, 30, resp);
      end else begin
        do_read(4'($urandom), a, len, -1, 30, cyc);
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
